// File: rtl/spdif_pkg.sv
// spdif_pkg: channel-status field map, block length and decoder states
// shared by the S/PDIF channel-status encoder and decoder.
package spdif_pkg;
    localparam int CS_BITS = 192;

    localparam int CONSUMER_POS = 0;
    localparam int LPCM_POS = 1;
    localparam int D_LSB = 3;
    localparam int D_W = 3;
    localparam int CAT_LSB = 8;
    localparam int CAT_W = 8;
    localparam int SRC_LSB = 16;
    localparam int SRC_W = 4;
    localparam int CHN_LSB = 20;
    localparam int CHN_W = 4;
    localparam int FS_LSB = 24;
    localparam int FS_W = 4;
    localparam int WL_LSB = 32;
    localparam int WL_W = 4;

    typedef enum logic [1:0] {
        HUNT,
        ARMED,
        COLLECT
    } cs_state_t;
endpackage

// File: rtl/spdif_channel_status_decoder_if.sv
// spdif_channel_status_decoder_if: subframe strobe inputs and decoded
// channel-status outputs of the decoder.
interface spdif_channel_status_decoder_if;
    import spdif_pkg::*;

    logic bitValid;
    logic subframeB;
    logic blockStart;
    logic csBit;
    logic [CS_BITS-1:0] channelStatus;
    logic consumer;
    logic linearPcm;
    logic [D_W-1:0] d;
    logic [CAT_W-1:0] categoryCode;
    logic [SRC_W-1:0] sourceNum;
    logic [CHN_W-1:0] channelNum;
    logic [FS_W-1:0] samplingFreq;
    logic [WL_W-1:0] wordLength;
    logic statusValid;
    logic locked;
    logic blockError;

    modport master (
        output bitValid, subframeB, blockStart, csBit,
        input channelStatus, consumer, linearPcm, d,
        input categoryCode, sourceNum, channelNum,
        input samplingFreq, wordLength,
        input statusValid, locked, blockError
    );

    modport slave (
        input bitValid, subframeB, blockStart, csBit,
        output channelStatus, consumer, linearPcm, d,
        output categoryCode, sourceNum, channelNum,
        output samplingFreq, wordLength,
        output statusValid, locked, blockError
    );
endinterface

// File: rtl/spdif_cs_fields.sv
// spdif_cs_fields: combinational slicer from a 192-bit consumer
// channel-status word to its named mode-0 fields.
module spdif_cs_fields
    import spdif_pkg::*;
(
    input  logic [CS_BITS-1:0] word,
    output logic consumer,
    output logic linearPcm,
    output logic [D_W-1:0] d,
    output logic [CAT_W-1:0] categoryCode,
    output logic [SRC_W-1:0] sourceNum,
    output logic [CHN_W-1:0] channelNum,
    output logic [FS_W-1:0] samplingFreq,
    output logic [WL_W-1:0] wordLength
);
    logic unused_bits;

    assign consumer = ~word[CONSUMER_POS];
    assign linearPcm = ~word[LPCM_POS];
    assign d = word[D_LSB +: D_W];
    assign categoryCode = word[CAT_LSB +: CAT_W];
    assign sourceNum = word[SRC_LSB +: SRC_W];
    assign channelNum = word[CHN_LSB +: CHN_W];
    assign samplingFreq = word[FS_LSB +: FS_W];
    assign wordLength = word[WL_LSB +: WL_W];

    assign unused_bits = ^{word[2], word[7:6], word[31:28],
                           word[CS_BITS-1:36]};
endmodule

// File: rtl/spdif_channel_status_decoder.sv
// spdif_channel_status_decoder: aligns per-subframe C bits to the block start
// and publishes the 192-bit word; SPDIF_CS_STABLE_EN adds a two-block match.
module spdif_channel_status_decoder
    import spdif_pkg::*;
#(
    parameter bit CHANNEL_SEL = 1'b0
) (
    input logic clk,
    input logic resetN,
    spdif_channel_status_decoder_if.slave bus
);
    localparam logic [7:0] LAST = 8'(CS_BITS - 1);

    cs_state_t state, state_n;
    logic [7:0] idx, idx_n, widx;
    logic [CS_BITS-1:0] shift, word, cs;
    logic a_sub, a_start, acc;
    logic store, done, err;
    logic status_valid, lock, block_error;

    assign a_sub = bus.bitValid & ~bus.subframeB;
    assign a_start = a_sub & bus.blockStart;
    assign acc = bus.bitValid & (bus.subframeB == CHANNEL_SEL);

    always_comb begin
        word = shift;
        word[CS_BITS-1] = bus.csBit;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= HUNT;
            idx <= 8'd0;
        end else begin
            state <= state_n;
            idx <= idx_n;
        end
    end

    // idx == 0 in COLLECT means a block just completed and frame 0 is due.
    always_comb begin
        state_n = state;
        idx_n = idx;
        widx = idx;
        store = 1'b0;
        done = 1'b0;
        err = 1'b0;
        unique case (state)
            HUNT: begin
                if (a_start) begin
                    state_n = CHANNEL_SEL ? ARMED : COLLECT;
                    store = ~CHANNEL_SEL;
                    widx = 8'd0;
                    idx_n = CHANNEL_SEL ? 8'd0 : 8'd1;
                end
            end
            ARMED: begin
                if (acc) begin
                    state_n = COLLECT;
                    store = 1'b1;
                    widx = 8'd0;
                    idx_n = 8'd1;
                end
            end
            COLLECT: begin
                if (a_start) begin
                    err = (idx != 8'd0);
                    state_n = CHANNEL_SEL ? ARMED : COLLECT;
                    store = ~CHANNEL_SEL;
                    widx = 8'd0;
                    idx_n = CHANNEL_SEL ? 8'd0 : 8'd1;
                end else if (a_sub && idx == 8'd0) begin
                    err = 1'b1;
                    state_n = HUNT;
                end else if (acc && idx != 8'd0) begin
                    store = 1'b1;
                    done = (idx == LAST);
                    idx_n = done ? 8'd0 : idx + 8'd1;
                end
            end
            default: state_n = HUNT;
        endcase
    end

`ifdef SPDIF_CS_STABLE_EN
    logic [CS_BITS-1:0] prev;
    logic have_prev;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shift <= '0;
            cs <= '0;
            status_valid <= 1'b0;
            lock <= 1'b0;
            block_error <= 1'b0;
`ifdef SPDIF_CS_STABLE_EN
            prev <= '0;
            have_prev <= 1'b0;
`endif
        end else begin
            status_valid <= 1'b0;
            block_error <= err;
            if (store) shift[widx] <= bus.csBit;
            if (err) lock <= 1'b0;
`ifdef SPDIF_CS_STABLE_EN
            if (err) have_prev <= 1'b0;
            if (done) begin
                prev <= word;
                have_prev <= 1'b1;
                if (have_prev && word == prev) begin
                    lock <= 1'b1;
                    if (word != cs) begin
                        cs <= word;
                        status_valid <= 1'b1;
                    end
                end
            end
`else
            if (done) begin
                cs <= word;
                status_valid <= 1'b1;
                lock <= 1'b1;
            end
`endif
        end
    end

    assign bus.channelStatus = cs;
    assign bus.statusValid = status_valid;
    assign bus.locked = lock;
    assign bus.blockError = block_error;

    spdif_cs_fields u_fields (
        .word(cs),
        .consumer(bus.consumer),
        .linearPcm(bus.linearPcm),
        .d(bus.d),
        .categoryCode(bus.categoryCode),
        .sourceNum(bus.sourceNum),
        .channelNum(bus.channelNum),
        .samplingFreq(bus.samplingFreq),
        .wordLength(bus.wordLength)
    );
endmodule
